// File: rtl/vram_arb_pkg.sv
// ============================================================================
// vram_arb_pkg -- shared widths, port index type and port numbering for VRAM arbitration
// Revision: 1.0
// ============================================================================
`default_nettype none

package vram_arb_pkg;

   localparam int VRAM_ADDR_W = 19;
   localparam int VRAM_DATA_W = 8;

   typedef logic [1:0] port_idx_t;

   localparam port_idx_t PORT_CPU = 2'd0;
   localparam port_idx_t PORT_DMA = 2'd1;
   localparam port_idx_t PORT_DBG = 2'd2;

endpackage

`default_nettype wire

// File: rtl/vram_arbiter_rr_pick.sv
// ============================================================================
// rr_pick -- combinational circular first-one picker starting after `last_i`
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import vram_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0] req_i,
   input  port_idx_t    last_i,
   output logic [N-1:0] gnt_o,
   output port_idx_t    idx_o,
   output logic         any_o
);

   logic w_found;

   // Candidate order is last+1, last+2, ... wrapping N-1 -> 0; last itself is tried last.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      w_found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!w_found && req_i[j] && (j == ((int'(last_i) + i) % N))) begin
               gnt_o[j] = 1'b1;
               idx_o    = port_idx_t'(j);
               w_found  = 1'b1;
            end
         end
      end
      any_o = w_found;
   end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// vram_arbiter -- one-slot-per-port VRAM bus arbiter, one access per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int NPORTS = 3,
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W,
   parameter int PRIO0  = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NPORTS-1:0]        p_strobe,
   input  logic [NPORTS-1:0]        p_write,
   input  logic [NPORTS*ADDR_W-1:0] p_addr,
   input  logic [NPORTS*DATA_W-1:0] p_wrdata,
   output logic [NPORTS-1:0]        p_busy,
   output logic [NPORTS*DATA_W-1:0] p_rddata,
   output logic [NPORTS-1:0]        p_rdvalid,
   output logic [NPORTS-1:0]        p_overrun,
   input  logic [NPORTS-1:0]        ovr_clr,
   output logic                     mem_strobe,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wrdata,
   input  logic [DATA_W-1:0]        mem_rddata
);

   logic [NPORTS-1:0] w_full;
   logic              w_slot_write [NPORTS];
   logic [ADDR_W-1:0] w_slot_addr  [NPORTS];
   logic [DATA_W-1:0] w_slot_data  [NPORTS];

   logic [NPORTS-1:0] w_rr_gnt;
   port_idx_t         w_rr_idx;
   logic              w_rr_any;
   logic [NPORTS-1:0] w_gnt;
   port_idx_t         w_idx;
   logic              w_any;

   logic              w_sel_write;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;

   port_idx_t         last_q;
   logic              mem_strobe_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wrdata_q;
   logic              tag_valid_q;
   port_idx_t         tag_port_q;
   logic              tag_write_q;

   rr_pick #(
      .N      (NPORTS)
   ) u_rr_pick (
      .req_i  (w_full),
      .last_i (last_q),
      .gnt_o  (w_rr_gnt),
      .idx_o  (w_rr_idx),
      .any_o  (w_rr_any)
   );

   always_comb begin
      w_gnt = w_rr_gnt;
      w_idx = w_rr_idx;
      w_any = w_rr_any;
      if ((PRIO0 != 0) && w_full[PORT_CPU]) begin
         w_gnt           = '0;
         w_gnt[PORT_CPU] = 1'b1;
         w_idx           = PORT_CPU;
         w_any           = 1'b1;
      end
   end

   always_comb begin
      w_sel_write = 1'b0;
      w_sel_addr  = '0;
      w_sel_data  = '0;
      for (int k = 0; k < NPORTS; k++) begin
         if (w_gnt[k]) begin
            w_sel_write = w_slot_write[k];
            w_sel_addr  = w_slot_addr[k];
            w_sel_data  = w_slot_data[k];
         end
      end
   end

   for (genvar k = 0; k < NPORTS; k++) begin : g_slot
      logic              full_q, full_d;
      logic              write_q;
      logic [ADDR_W-1:0] addr_q;
      logic [DATA_W-1:0] data_q;
      logic              ovr_q, ovr_d;
      logic              rdv_q;
      logic [DATA_W-1:0] rdd_q;
      logic              w_take, w_drop, w_resp;

      // A slot being granted this cycle may be refilled in the same edge.
      assign w_take = p_strobe[k] && (!full_q || w_gnt[k]);
      assign w_drop = p_strobe[k] && full_q && !w_gnt[k];
      assign w_resp = tag_valid_q && !tag_write_q && (tag_port_q == port_idx_t'(k));

      always_comb begin
         full_d = full_q;
         ovr_d  = ovr_q;
         if (w_take) begin
            full_d = 1'b1;
         end else if (w_gnt[k]) begin
            full_d = 1'b0;
         end
         if (w_drop) begin
            ovr_d = 1'b1;
         end else if (ovr_clr[k]) begin
            ovr_d = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            full_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            rdv_q   <= 1'b0;
            rdd_q   <= '0;
         end else begin
            full_q <= full_d;
            ovr_q  <= ovr_d;
            rdv_q  <= w_resp;
            if (w_take) begin
               write_q <= p_write[k];
               addr_q  <= p_addr[k*ADDR_W +: ADDR_W];
               data_q  <= p_wrdata[k*DATA_W +: DATA_W];
            end
            if (w_resp) begin
               rdd_q <= mem_rddata;
            end
         end
      end

      assign w_full[k]                     = full_q;
      assign w_slot_write[k]               = write_q;
      assign w_slot_addr[k]                = addr_q;
      assign w_slot_data[k]                = data_q;
      assign p_busy[k]                     = full_q;
      assign p_overrun[k]                  = ovr_q;
      assign p_rdvalid[k]                  = rdv_q;
      assign p_rddata[k*DATA_W +: DATA_W]  = rdd_q;
   end

   // The tag travels one stage behind the access so read data lands on its issuer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q       <= port_idx_t'(NPORTS - 1);
         mem_strobe_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wrdata_q <= '0;
         tag_valid_q  <= 1'b0;
         tag_port_q   <= '0;
         tag_write_q  <= 1'b0;
      end else begin
         mem_strobe_q <= w_any;
         tag_valid_q  <= w_any;
         if (w_any) begin
            last_q       <= w_idx;
            mem_write_q  <= w_sel_write;
            mem_addr_q   <= w_sel_addr;
            mem_wrdata_q <= w_sel_data;
            tag_port_q   <= w_idx;
            tag_write_q  <= w_sel_write;
         end
      end
   end

   assign mem_strobe = mem_strobe_q;
   assign mem_write  = mem_write_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wrdata = mem_wrdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// tb_vram_arbiter -- round-robin and CPU-priority instances against a cycle reference model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vram_arbiter;

   localparam int N  = 3;
   localparam int AW = 19;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    strobe, wr, clr;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wd;

   logic [N-1:0]    busy [2];
   logic [N-1:0]    rdv  [2];
   logic [N-1:0]    ovr  [2];
   logic [N*DW-1:0] rdd  [2];
   logic            ms   [2];
   logic            mw   [2];
   logic [AW-1:0]   ma   [2];
   logic [DW-1:0]   mwd  [2];
   logic [DW-1:0]   mrd  [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instance 0 is pure round-robin, instance 1 gives port 0 absolute priority.
   vram_arbiter #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO0(0)) u_rr (
      .clk(clk), .rst_n(rst_n), .p_strobe(strobe), .p_write(wr), .p_addr(addr),
      .p_wrdata(wd), .p_busy(busy[0]), .p_rddata(rdd[0]), .p_rdvalid(rdv[0]),
      .p_overrun(ovr[0]), .ovr_clr(clr), .mem_strobe(ms[0]), .mem_write(mw[0]),
      .mem_addr(ma[0]), .mem_wrdata(mwd[0]), .mem_rddata(mrd[0]));

   vram_arbiter #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO0(1)) u_prio (
      .clk(clk), .rst_n(rst_n), .p_strobe(strobe), .p_write(wr), .p_addr(addr),
      .p_wrdata(wd), .p_busy(busy[1]), .p_rddata(rdd[1]), .p_rdvalid(rdv[1]),
      .p_overrun(ovr[1]), .ovr_clr(clr), .mem_strobe(ms[1]), .mem_write(mw[1]),
      .mem_addr(ma[1]), .mem_wrdata(mwd[1]), .mem_rddata(mrd[1]));

   function automatic logic [7:0] pat(input logic [9:0] a);
      if (a == 10'h345) return 8'hA5;
      return 8'(int'(a) * 7 + 3);
   endfunction

   // VRAM models: 1K image aliased on the low address bits, background pattern until written.
   bit [7:0] emem0 [1024];
   bit       ewr0  [1024];
   bit [7:0] emem1 [1024];
   bit       ewr1  [1024];
   assign mrd[0] = ewr0[ma[0][9:0]] ? emem0[ma[0][9:0]] : pat(ma[0][9:0]);
   assign mrd[1] = ewr1[ma[1][9:0]] ? emem1[ma[1][9:0]] : pat(ma[1][9:0]);
   always @(posedge clk) if (ms[0] && mw[0]) begin emem0[ma[0][9:0]] <= mwd[0]; ewr0[ma[0][9:0]] <= 1'b1; end
   always @(posedge clk) if (ms[1] && mw[1]) begin emem1[ma[1][9:0]] <= mwd[1]; ewr1[ma[1][9:0]] <= 1'b1; end

   // Reference model state, one set per instance.
   bit            m_full [2][N];
   bit            m_wr   [2][N];
   logic [AW-1:0] m_addr [2][N];
   logic [DW-1:0] m_wd   [2][N];
   bit            m_ovr  [2][N];
   bit            m_rdv  [2][N];
   logic [DW-1:0] m_rdd  [2][N];
   int            m_last [2];
   bit            m_ms   [2];
   bit            m_mw   [2];
   logic [AW-1:0] m_ma   [2];
   logic [DW-1:0] m_mwd  [2];
   bit            m_tv   [2];
   int            m_tp   [2];
   bit            m_tw   [2];
   logic [DW-1:0] m_td   [2];
   bit [7:0]      mm     [2][1024];
   bit            mmw    [2][1024];

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         int win;
         int mi;
         if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
               m_full[d][k] = 0; m_ovr[d][k] = 0; m_rdv[d][k] = 0; m_rdd[d][k] = '0;
            end
            m_last[d] = N - 1; m_ms[d] = 0; m_mw[d] = 0; m_ma[d] = '0; m_mwd[d] = '0; m_tv[d] = 0;
            continue;
         end
         for (int k = 0; k < N; k++) m_rdv[d][k] = 0;
         if (m_tv[d] && !m_tw[d]) begin
            m_rdv[d][m_tp[d]] = 1;
            m_rdd[d][m_tp[d]] = m_td[d];
         end
         win = -1;
         if (d == 1 && m_full[d][0]) win = 0;
         else begin
            for (int i = 1; i <= N; i++) begin
               int c = (m_last[d] + i) % N;
               if (win < 0 && m_full[d][c]) win = c;
            end
         end
         m_ms[d] = (win >= 0);
         m_tv[d] = (win >= 0);
         if (win >= 0) begin
            m_mw[d] = m_wr[d][win]; m_ma[d] = m_addr[d][win]; m_mwd[d] = m_wd[d][win];
            m_tp[d] = win; m_tw[d] = m_wr[d][win]; m_last[d] = win;
            mi = int'(m_addr[d][win][9:0]);
            if (m_wr[d][win]) begin
               mm[d][mi] = m_wd[d][win]; mmw[d][mi] = 1;
            end else begin
               m_td[d] = mmw[d][mi] ? mm[d][mi] : pat(m_addr[d][win][9:0]);
            end
         end
         for (int k = 0; k < N; k++) begin
            if (clr[k]) m_ovr[d][k] = 0;
            if (strobe[k]) begin
               if (!m_full[d][k] || win == k) begin
                  m_full[d][k] = 1; m_wr[d][k] = wr[k];
                  m_addr[d][k] = addr[k*AW +: AW]; m_wd[d][k] = wd[k*DW +: DW];
               end else begin
                  m_ovr[d][k] = 1;
               end
            end else if (win == k) begin
               m_full[d][k] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      strobe = '0;
      clr    = '0;
   endtask

   task automatic req(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] dat);
      strobe[k]         = 1'b1;
      wr[k]             = w;
      addr[k*AW +: AW]  = a;
      wd[k*DW +: DW]    = dat;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({busy[d], ovr[d], rdv[d], ms[d]} !== '0) begin
            errors++;
            $display("FAIL reset_flags dut%0d busy=%b ovr=%b rdv=%b ms=%b want all 0", d, busy[d], ovr[d], rdv[d], ms[d]);
         end
         checks++;
         if ({ma[d], mwd[d], mw[d], rdd[d]} !== '0) begin
            errors++;
            $display("FAIL reset_data dut%0d addr=%h wd=%h w=%b rdd=%h want all 0", d, ma[d], mwd[d], mw[d], rdd[d]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      req(1, 1'b0, 19'h12345, 8'h00);
      tick();
      idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (busy[d] !== 3'b010) begin
            errors++; $display("FAIL single_busy dut%0d got %b want 010", d, busy[d]);
         end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ms[d] !== 1'b1 || ma[d] !== 19'h12345 || rdv[d] !== 3'b000) begin
            errors++; $display("FAIL single_mem dut%0d ms=%b addr=%h rdv=%b want 1 12345 000", d, ms[d], ma[d], rdv[d]);
         end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rdv[d] !== 3'b010 || rdd[d][15:8] !== 8'hA5 || ms[d] !== 1'b0) begin
            errors++; $display("FAIL single_rsp dut%0d rdv=%b data=%h ms=%b want 010 a5 0", d, rdv[d], rdd[d][15:8], ms[d]);
         end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rdv[d] !== 3'b000) begin
            errors++; $display("FAIL single_pulse dut%0d rdv=%b want 000", d, rdv[d]);
         end
      end
   endtask

   task automatic test_all_three();
      logic [AW-1:0] a [3];
      a[0] = 19'h00100; a[1] = 19'h40201; a[2] = 19'h00302;
      do_reset();
      for (int k = 0; k < 3; k++) req(k, 1'b0, a[k], 8'h00);
      tick();
      idle();
      for (int s = 0; s < 4; s++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            if (s < 3) begin
               checks++;
               if (ms[d] !== 1'b1 || ma[d] !== a[s]) begin
                  errors++; $display("FAIL all3_grant%0d dut%0d ms=%b addr=%h want 1 %h", s, d, ms[d], ma[d], a[s]);
               end
            end
            if (s >= 1) begin
               checks++;
               if (rdv[d] !== 3'(1 << (s - 1)) || rdd[d][(s-1)*DW +: DW] !== pat(a[s-1][9:0])) begin
                  errors++;
                  $display("FAIL all3_rsp%0d dut%0d rdv=%b data=%h want %b %h", s - 1, d, rdv[d],
                           rdd[d][(s-1)*DW +: DW], 3'(1 << (s - 1)), pat(a[s-1][9:0]));
               end
            end
         end
      end
   endtask

   task automatic test_prio();
      bit            e_ms [7];
      logic [AW-1:0] e_ma [7];
      e_ms = '{0, 1, 1, 1, 0, 1, 0};
      e_ma = '{19'h0, 19'h00020, 19'h00021, 19'h00022, 19'h0, 19'h00023, 19'h0};
      do_reset();
      for (int c = 0; c < 7; c++) begin
         if (c == 0) begin
            req(0, 1'b0, 19'h00020, 8'h00);
            req(1, 1'b1, 19'h00021, 8'h77);
         end
         if (c == 2) req(0, 1'b0, 19'h00022, 8'h00);
         if (c == 4) req(0, 1'b0, 19'h00023, 8'h00);
         tick();
         idle();
         checks++;
         if (ms[1] !== e_ms[c] || (e_ms[c] && (ma[1] !== e_ma[c] || mw[1] !== (c == 2)))) begin
            errors++;
            $display("FAIL prio_cycle%0d ms=%b addr=%h w=%b want %b %h %b", c, ms[1], ma[1], mw[1], e_ms[c], e_ma[c], (c == 2));
         end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      req(0, 1'b0, 19'h00030, 8'h00);
      req(2, 1'b0, 19'h00032, 8'h00);
      tick(); idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (busy[d] !== 3'b101 || ovr[d] !== 3'b000) begin
            errors++; $display("FAIL ovr_capture dut%0d busy=%b ovr=%b want 101 000", d, busy[d], ovr[d]);
         end
      end
      req(2, 1'b0, 19'h00033, 8'h00);
      tick(); idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (busy[d] !== 3'b100 || ovr[d] !== 3'b100) begin
            errors++; $display("FAIL ovr_drop dut%0d busy=%b ovr=%b want 100 100", d, busy[d], ovr[d]);
         end
      end
      clr[2] = 1'b1;
      tick(); idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (busy[d] !== 3'b000 || ovr[d] !== 3'b000) begin
            errors++; $display("FAIL ovr_clear dut%0d busy=%b ovr=%b want 000 000", d, busy[d], ovr[d]);
         end
      end
      req(0, 1'b0, 19'h00034, 8'h00);
      req(2, 1'b0, 19'h00035, 8'h00);
      tick(); idle();
      req(2, 1'b0, 19'h00036, 8'h00);
      clr[2] = 1'b1;
      tick(); idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ovr[d][2] !== 1'b1) begin
            errors++; $display("FAIL ovr_set_wins dut%0d ovr2=%b want 1", d, ovr[d][2]);
         end
      end
      clr[2] = 1'b1;
      tick(); idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ovr[d][2] !== 1'b0) begin
            errors++; $display("FAIL ovr_clear2 dut%0d ovr2=%b want 0", d, ovr[d][2]);
         end
      end
      tick(); tick(); tick();
   endtask

   task automatic test_write_readback();
      req(0, 1'b1, 19'h00010, 8'h3C);
      tick(); idle();
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ms[d] !== 1'b1 || mw[d] !== 1'b1 || ma[d] !== 19'h00010 || mwd[d] !== 8'h3C) begin
            errors++; $display("FAIL wr_access dut%0d ms=%b w=%b addr=%h wd=%h want 1 1 00010 3c", d, ms[d], mw[d], ma[d], mwd[d]);
         end
      end
      req(1, 1'b0, 19'h00010, 8'h00);
      tick(); idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rdv[d] !== 3'b000) begin
            errors++; $display("FAIL wr_no_rsp dut%0d rdv=%b want 000", d, rdv[d]);
         end
      end
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rdv[d] !== 3'b010 || rdd[d][15:8] !== 8'h3C) begin
            errors++; $display("FAIL wr_readback dut%0d rdv=%b data=%h want 010 3c", d, rdv[d], rdd[d][15:8]);
         end
      end
   endtask

   task automatic test_reset_midop();
      for (int k = 0; k < 3; k++) req(k, 1'b0, 19'(20'h00050 + k), 8'h00);
      tick(); idle();
      tick();
      rst_n = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({busy[d], ovr[d], rdv[d], ms[d], mw[d], ma[d], mwd[d], rdd[d]} !== '0) begin
            errors++;
            $display("FAIL midop_reset dut%0d busy=%b rdv=%b ms=%b addr=%h rdd=%h want all 0", d, busy[d], rdv[d], ms[d], ma[d], rdd[d]);
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdv[d] !== 3'b000 || ms[d] !== 1'b0) begin
               errors++; $display("FAIL midop_quiet%0d dut%0d rdv=%b ms=%b want 000 0", c, d, rdv[d], ms[d]);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         for (int k = 0; k < N; k++) begin
            strobe[k]        = ($urandom_range(0, 9) < 4);
            wr[k]            = ($urandom_range(0, 2) == 0);
            addr[k*AW +: AW] = AW'($urandom) & 19'h7C03F;
            wd[k*DW +: DW]   = DW'($urandom);
            clr[k]           = ($urandom_range(0, 9) == 0);
         end
         tick();
         for (int d = 0; d < 2; d++) begin
            logic [N-1:0]    eb, eo, ev;
            logic [N*DW-1:0] er;
            for (int k = 0; k < N; k++) begin
               eb[k] = m_full[d][k]; eo[k] = m_ovr[d][k]; ev[k] = m_rdv[d][k];
               er[k*DW +: DW] = m_rdd[d][k];
            end
            checks++;
            if ({busy[d], ovr[d], rdv[d]} !== {eb, eo, ev}) begin
               errors++;
               $display("FAIL rand_flags c%0d dut%0d busy/ovr/rdv=%b/%b/%b want %b/%b/%b", c, d, busy[d], ovr[d], rdv[d], eb, eo, ev);
            end
            checks++;
            if (rdd[d] !== er) begin
               errors++; $display("FAIL rand_rddata c%0d dut%0d got %h want %h", c, d, rdd[d], er);
            end
            checks++;
            if (ms[d] !== m_ms[d]) begin
               errors++; $display("FAIL rand_strobe c%0d dut%0d got %b want %b", c, d, ms[d], m_ms[d]);
            end
            if (m_ms[d]) begin
               checks++;
               if ({mw[d], ma[d], mwd[d]} !== {m_mw[d], m_ma[d], m_mwd[d]}) begin
                  errors++;
                  $display("FAIL rand_access c%0d dut%0d w/addr/wd=%b/%h/%h want %b/%h/%h", c, d, mw[d], ma[d], mwd[d], m_mw[d], m_ma[d], m_mwd[d]);
               end
            end
         end
      end
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      rst_n  = 1'b0;
      strobe = '0;
      wr     = '0;
      clr    = '0;
      addr   = '0;
      wd     = '0;
      test_reset();
      test_single_read();
      test_all_three();
      test_prio();
      test_overrun();
      test_write_readback();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single video-RAM bus-master port among up to four requesters: the 6502 external-bus interface, the layer/sprite fetch DMA and the debug/SPI bridge. Each requester issues single-beat strobes with no stall signal; the arbiter buffers one access per port, grants one access per cycle to the memory side, and routes read data back to the issuing port with a valid pulse. It sits between the requester blocks and the VRAM controller in the `clk` domain.

## Interface
- `NPORTS`, 3: number of requester ports, 2–4.
- `ADDR_W`, 19: VRAM byte address width.
- `DATA_W`, 8: data width.
- `PRIO0`, 1: 1 means port 0 (CPU) has absolute priority; 0 means pure round-robin.
- `clk`  in  1  system clock, the single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `p_strobe`  in  NPORTS  one-cycle request pulse per port.
- `p_write`  in  NPORTS  1 = write, 0 = read; qualified by `p_strobe`.
- `p_addr`  in  NPORTS*ADDR_W  request address; port k occupies slice k.
- `p_wrdata`  in  NPORTS*DATA_W  write data.
- `p_busy`  out  NPORTS  the port's holding slot is occupied.
- `p_rddata`  out  NPORTS*DATA_W  read data, held until the next read completes on that port.
- `p_rdvalid`  out  NPORTS  one-cycle pulse when `p_rddata` updates.
- `p_overrun`  out  NPORTS  sticky flag: a strobe was dropped.
- `ovr_clr`  in  NPORTS  clears the matching `p_overrun` bit.
- `mem_strobe`  out  1  registered access strobe to VRAM.
- `mem_write`  out  1  registered access direction.
- `mem_addr`  out  ADDR_W  registered access address.
- `mem_wrdata`  out  DATA_W  registered write data.
- `mem_rddata`  in  DATA_W  valid in the cycle after `mem_strobe` for reads.

## Operation
- Per-port slot holds {write, addr, wrdata} and a full bit. `p_busy` equals the full bit.
- A strobe is captured when the slot is empty, or when the slot is being granted in the same cycle (back-to-back issue is allowed).
- A strobe on a busy, non-granted slot is dropped and sets `p_overrun[k]`. If a drop and `ovr_clr[k]` occur in the same cycle, set wins.
- Arbitration runs every cycle over the full slots:
  - `PRIO0`=1: port 0 wins whenever it is full.
  - Otherwise the first full port after `last_grant` in circular order wins, using index wrap NPORTS-1 → 0.
  - `last_grant` updates only on a grant. Its reset value is NPORTS-1, so port 0 is first.
- A grant loads the `mem_*` registers, asserts `mem_strobe` for one cycle, and clears the slot unless a new strobe refills it.
- In-flight tag: {valid, port, write} is registered alongside `mem_strobe`. In the next cycle, a read tag captures `mem_rddata` into `p_rddata[port]` and pulses `p_rdvalid[port]`. A write tag produces no response.
- There is no state machine beyond the slots, the tag stage and `last_grant`. Throughput is one access per cycle sustained.
- Reset values (after `rst_n` is low on a clock edge):
  - slots, `p_busy`, `p_overrun`, `p_rdvalid`, `mem_strobe`: 0
  - `p_rddata`, `mem_addr`, `mem_wrdata`, `mem_write`: 0
  - tag valid: 0
- Reset mid-operation discards pending slots and in-flight read data; no `p_rdvalid` is generated for them.

## Timing
- Strobe sampled at edge t with slot empty and the port winning: `mem_strobe` is high in cycle t+1, `mem_rddata` is sampled at edge t+2, and `p_rdvalid` is high in cycle t+2 (registered, visible after edge t+2).
- Read latency from strobe edge to `p_rdvalid` is 2 cycles when uncontended, plus 1 cycle per access granted ahead of it.
- With `PRIO0`=0, worst-case wait is NPORTS-1 grants. With `PRIO0`=1, ports 1..N-1 may starve; port 0 must not strobe more often than every 2 cycles.
- `p_busy` rises in the cycle after the capturing edge and falls in the cycle after the granting edge.

## Structure
- Shared package `vram_arb_pkg`: `VRAM_ADDR_W` = 19, `VRAM_DATA_W` = 8, `port_idx_t` (2-bit), and the port numbering constants `PORT_CPU` = 0, `PORT_DMA` = 1, `PORT_DBG` = 2.
- Sub-module `rr_pick`: combinational circular first-one picker with a `last` input and a one-hot grant plus index output; the `PRIO0` override is applied outside it.
- Slots are generated per port in a loop.

## Test plan
- Single read on port 1, addr 0x1_2345, VRAM returns 0xA5 → `mem_strobe` at t+1 with `mem_addr` = 0x12345; `p_rdvalid[1]` and `p_rddata[1]` = 0xA5 at t+2; other ports' `p_rdvalid` stays 0.
- All three ports strobe reads in the same cycle with `PRIO0`=0 → grants in order 0, 1, 2 on consecutive cycles; each port receives its own data value, with no cross-routing.
- `PRIO0`=1, port 0 strobing every 2 cycles while port 1 holds a pending write → port 0 is granted each time, and port 1 is granted in the idle cycles between.
- Port 2 strobes twice while busy → the second request is dropped and `p_overrun[2]` = 1. `ovr_clr[2]` clears it, except in a cycle with a simultaneous drop, where the flag stays 1.
- Write 0x3C to 0x00010 on port 0, then read it back on port 1 with a memory model → `p_rddata[1]` = 0x3C; the write produces no `p_rdvalid`.
- `rst_n` is asserted low while slots are full and a read is in flight → the next cycle shows all outputs 0, and no `p_rdvalid` appears after release.
